// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
// Holds the FSM state enum, default sizes and width functions.
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_OUT
  } state_e;

  localparam int P_DW = 8;
  localparam int P_N  = 4;
  localparam int P_K  = 4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int feed_len(input int k, input int n);
    return k + 2 * n - 2;
  endfunction

  function automatic int res_w(input int dw);
    return 2 * dw + 1;
  endfunction

  localparam int P_F  = feed_len(P_K, P_N);
  localparam int P_KW = cnt_w(P_K);
  localparam int P_NW = cnt_w(P_N);
  localparam int P_FW = cnt_w(P_F);

endpackage

// File: rtl/systolic_skew.sv
// Diagonal skew for one array edge: lane g is delayed g cycles.
// Ports: clk, rst, clr (flush), fill (lane input valid), d/q lanes.
module systolic_skew #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          fill,
  input  logic [N*DW-1:0] d,
  output logic [N*DW-1:0] q
);

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [DW-1:0] din;

    // Invalid slots enter the pipe as zero.
    assign din = fill ? d[g*DW +: DW] : '0;

    if (g == 0) begin : g_comb
      assign q[DW-1:0] = din;
    end else begin : g_reg
      logic [DW-1:0] sr [g];

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int s = 0; s < g; s++)
            sr[s] <= '0;
        end else begin
          sr[0] <= din;
          for (int s = 1; s < g; s++)
            sr[s] <= sr[s-1];
        end
      end

      assign q[g*DW +: DW] = sr[g-1];
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary systolic array.
// Clears, feeds skewed operands, then streams results row-major.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DW = P_DW,
  parameter int N  = P_N,
  parameter int K  = P_K
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [cnt_w(K)-1:0]        rd_addr,
  input  logic [N*DW-1:0]            a_rd_data,
  input  logic [N*DW-1:0]            b_rd_data,
  output logic                       arr_clr,
  output logic [N*DW-1:0]            x_edge,
  output logic [N*DW-1:0]            y_edge,
  input  logic [N*N*res_w(DW)-1:0]   pe_out_flat,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [res_w(DW)-1:0]       res_data,
  output logic [cnt_w(N)-1:0]        res_row,
  output logic [cnt_w(N)-1:0]        res_col
);

  localparam int F  = feed_len(K, N);
  localparam int AW = cnt_w(K);
  localparam int FW = cnt_w(F);
  localparam int IW = cnt_w(N);
  localparam int RW = res_w(DW);

  state_e        st, st_nx;
  logic [FW-1:0] f_q, f_nx;
  logic [IW-1:0] r_q, r_nx;
  logic [IW-1:0] c_q, c_nx;
  logic          fill;
  logic          skew_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= S_IDLE;
      f_q <= '0;
      r_q <= '0;
      c_q <= '0;
    end else begin
      st  <= st_nx;
      f_q <= f_nx;
      r_q <= r_nx;
      c_q <= c_nx;
    end
  end

  always_comb begin
    st_nx = st;
    f_nx  = f_q;
    r_nx  = r_q;
    c_nx  = c_q;
    done  = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (start)
          st_nx = S_CLEAR;
      end
      S_CLEAR: begin
        st_nx = S_FEED;
        f_nx  = '0;
      end
      S_FEED: begin
        if (f_q == FW'(F - 1)) begin
          st_nx = S_OUT;
          f_nx  = '0;
          r_nx  = '0;
          c_nx  = '0;
        end else begin
          f_nx = f_q + 1'b1;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          if (c_q == IW'(N - 1)) begin
            c_nx = '0;
            if (r_q == IW'(N - 1)) begin
              r_nx  = '0;
              st_nx = S_IDLE;
              done  = 1'b1;
            end else begin
              r_nx = r_q + 1'b1;
            end
          end else begin
            c_nx = c_q + 1'b1;
          end
        end
      end
      default: st_nx = S_IDLE;
    endcase
  end

  // Read one slice ahead: data for slot f arrives in FEED cycle f.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (st == S_CLEAR) begin
      rd_en = 1'b1;
    end else if (st == S_FEED && (int'(f_q) + 1 < K)) begin
      rd_en   = 1'b1;
      rd_addr = AW'(f_q + 1'b1);
    end
  end

  assign busy      = (st != S_IDLE);
  assign arr_clr   = (st == S_CLEAR);
  assign res_valid = (st == S_OUT);
  assign res_row   = r_q;
  assign res_col   = c_q;
  assign res_data  = (st == S_OUT) ?
    pe_out_flat[(int'(r_q) * N + int'(c_q)) * RW +: RW] : '0;

  assign fill     = (st == S_FEED) && (int'(f_q) < K);
  assign skew_clr = (st == S_CLEAR);

  systolic_skew #(.DW(DW), .N(N)) u_skew_x (
    .clk  (clk),
    .rst  (rst),
    .clr  (skew_clr),
    .fill (fill),
    .d    (a_rd_data),
    .q    (x_edge)
  );

  systolic_skew #(.DW(DW), .N(N)) u_skew_y (
    .clk  (clk),
    .rst  (rst),
    .clr  (skew_clr),
    .fill (fill),
    .d    (b_rd_data),
    .q    (y_edge)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with operand buffers and a PE grid model.
// Checks result streams, timing, back-pressure, busy start and reset.
module tb_systolic_ctrl;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int K  = 4;
  localparam int RW = 2 * DW + 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   rd_en;
  logic [1:0]             rd_addr;
  logic [N*DW-1:0]        a_rd_data;
  logic [N*DW-1:0]        b_rd_data;
  logic                   arr_clr;
  logic [N*DW-1:0]        x_edge;
  logic [N*DW-1:0]        y_edge;
  logic [N*N*RW-1:0]      pe_out_flat;
  logic                   res_valid;
  logic                   res_ready;
  logic signed [RW-1:0]   res_data;
  logic [1:0]             res_row;
  logic [1:0]             res_col;

  int nvec = 0;
  int nerr = 0;

  logic signed [DW-1:0] am [N][K];
  logic signed [DW-1:0] bm [K][N];
  int                   expv [N*N];

  logic signed [RW-1:0] acc [N][N];
  logic signed [DW-1:0] xr  [N][N];
  logic signed [DW-1:0] yr  [N][N];
  logic signed [DW-1:0] xw  [N][N];
  logic signed [DW-1:0] yw  [N][N];

  always #5 clk = ~clk;

  systolic_ctrl #(.DW(DW), .N(N), .K(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .a_rd_data   (a_rd_data),
    .b_rd_data   (b_rd_data),
    .arr_clr     (arr_clr),
    .x_edge      (x_edge),
    .y_edge      (y_edge),
    .pe_out_flat (pe_out_flat),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_row     (res_row),
    .res_col     (res_col)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      for (int i = 0; i < N; i++) begin
        a_rd_data[i*DW +: DW] <= am[i][rd_addr];
        b_rd_data[i*DW +: DW] <= bm[rd_addr][i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      xw[i][0] = x_edge[i*DW +: DW];
      yw[0][i] = y_edge[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        xw[i][j] = xr[i][j-1];
        yw[j][i] = yr[j-1][i];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (arr_clr) begin
          acc[i][j] <= '0;
          xr[i][j]  <= '0;
          yr[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + xw[i][j] * yw[i][j];
          xr[i][j]  <= xw[i][j];
          yr[i][j]  <= yw[i][j];
        end
      end
  end

  always_comb begin
    pe_out_flat = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        pe_out_flat[(i*N+j)*RW +: RW] = acc[i][j];
  end

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, rd_en, 0);
    chk({tag, "_addr"}, rd_addr, 0);
    chk({tag, "_clr"}, arr_clr, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_xedge"}, (x_edge != 0), 0);
    chk({tag, "_yedge"}, (y_edge != 0), 0);
  endtask

  task automatic run_job(input int stall_at, input int pulse_at,
                         input int exp_done);
    int cyc, idx, nclr, first_v, done_cyc, stalls;
    cyc = 1; idx = 0; nclr = 0;
    first_v = 0; done_cyc = 0; stalls = 0;
    @(negedge clk);
    start = 1'b1;
    res_ready = 1'b1;
    #1;
    chk("start_idle", busy, 0);
    while (done_cyc == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_at);
      res_ready = !(idx == stall_at && stalls < 3);
      #1;
      if (arr_clr) nclr++;
      if (res_valid && first_v == 0) first_v = cyc;
      if (res_valid && !res_ready) begin
        stalls++;
        chk("hold_row", res_row, idx / N);
        chk("hold_col", res_col, idx % N);
        chk("hold_data", res_data, expv[idx]);
      end
      if (res_valid && res_ready && idx < N*N) begin
        chk("res_row", res_row, idx / N);
        chk("res_col", res_col, idx % N);
        chk("res_data", res_data, expv[idx]);
        idx++;
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, exp_done);
    chk("first_valid", first_v, 13);
    chk("clr_pulses", nclr, 1);
    chk("n_results", idx, N*N);
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        am[i][k] = (i == k) ? 8'sd1 : 8'sd0;
        bm[k][i] = DW'(k*4 + i + 1);
      end
    for (int n = 0; n < N*N; n++) expv[n] = n + 1;
  endtask

  task automatic set_const(input int a, input int b, input int e);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        am[i][k] = DW'(a);
        bm[k][i] = DW'(b);
      end
    for (int n = 0; n < N*N; n++) expv[n] = e;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    res_ready = 1'b0;
    set_identity();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_quiet("reset");

    set_identity();
    run_job(-1, 0, 28);

    // Back-to-back jobs: sums must not carry over.
    set_const(127, 127, 64516);
    run_job(-1, 0, 28);
    set_const(-128, 127, -65024);
    run_job(-1, 0, 28);

    set_identity();
    run_job(5, 0, 31);

    // Start pulsed during FEED must be ignored.
    set_identity();
    run_job(-1, 5, 28);
    begin
      int extra;
      extra = 0;
      repeat (6) begin
        @(negedge clk);
        #1;
        if (done || busy) extra++;
      end
      chk("no_restart", extra, 0);
    end

    // Reset at FEED f=3.
    set_identity();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("f3_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_quiet("midrst");

    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        am[i][k] = 8'sd1;
        bm[k][i] = DW'(k - i);
      end
    for (int n = 0; n < N*N; n++) expv[n] = 6 - 4 * (n % N);
    run_job(-1, 0, 28);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for an N×N output-stationary systolic array of signed multiply-accumulate PEs. On `start` it clears the array, reads K operand slices from external A/B buffers and feeds them onto the array edges with the required diagonal skew. It then holds the array idle and streams the N×N accumulated results out row-major over a valid/ready port. It sits between the operand buffers and the PE grid, and drives the grid's `clr` and edge `x_i`/`y_i` inputs.

## Interface

Parameters:
- `DW`, 8: operand width, signed.
- `N`, 4: array dimension (rows = cols).
- `K`, 4: inner dimension, the number of operand slices per job; K ≥ 1.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: job request, sampled in IDLE only.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the last result is accepted.
- `rd_en`, out, 1: operand buffer read strobe.
- `rd_addr`, out, clog2(K) (minimum 1): slice index k.
- `a_rd_data`, in, N*DW: column k of A. Lane i is A[i][k]. Valid the cycle after `rd_en`.
- `b_rd_data`, in, N*DW: row k of B. Lane j is B[k][j]. Valid the cycle after `rd_en`.
- `arr_clr`, out, 1: to every PE's `clr`.
- `x_edge`, out, N*DW: lane i goes to the `x_i` input of row i, column 0.
- `y_edge`, out, N*DW: lane j goes to the `y_i` input of row 0, column j.
- `pe_out_flat`, in, N*N*(2DW+1): PE(i,j) accumulator at lane i*N+j.
- `res_valid`, out, 1: result handshake valid.
- `res_ready`, in, 1: result handshake ready.
- `res_data`, out, 2DW+1: signed result.
- `res_row`, out, clog2(N) (minimum 1): row index of the current result.
- `res_col`, out, clog2(N) (minimum 1): column index of the current result.

## Operation

States: IDLE, CLEAR, FEED, OUT.

- **IDLE**
  - All outputs are 0.
  - `start`=1 moves to CLEAR.
- **CLEAR** (1 cycle)
  - `arr_clr`=1.
  - `rd_en`=1, `rd_addr`=0.
  - Moves to FEED with f=0.
- **FEED** (cycles f = 0 .. F-1, where F = K+2N-2)
  - `rd_en`=1 with `rd_addr`=f+1 while f+1 < K; otherwise `rd_en`=0.
  - Edge values:
    - `x_edge[i]` = A[i][f-i] if 0 ≤ f-i < K, else 0.
    - `y_edge[j]` = B[f-j][j] if 0 ≤ f-j < K, else 0.
  - Lane 0 carries zero delay. Lane i is delayed i cycles through a skew shift register. Slots outside the valid range are zero-filled.
  - Moves to OUT after f = F-1.
- **OUT**
  - Edges are driven to 0, so PE accumulators are stable (0×0 adds nothing).
  - `res_valid`=1.
  - `res_data` = `pe_out_flat` lane r*N+c, with (r,c) stepping row-major from (0,0).
  - The index advances only on `res_valid & res_ready`.
  - Acceptance of (N-1,N-1) moves to IDLE and pulses `done` in that same transition cycle.

Arithmetic and boundary rules:
- Width: the result is a (2DW+1)-bit two's-complement accumulation. Overflow wraps; the controller does no saturation and performs no arithmetic.
- `start` while busy: ignored, not queued.
- `start` held high through `done`: a new job begins one cycle after IDLE is re-entered.
- `rst` in any state:
  - Next state is IDLE.
  - Counters, skew registers and the index are zeroed.
  - `arr_clr`, `rd_en`, `res_valid` and `done` are 0.
- Back-pressure: `res_ready` low holds `res_data`, `res_row` and `res_col` unchanged.

## Timing

- `start` to `arr_clr`: 1 cycle.
- First `res_valid`: 2+F cycles after the `start` sample, when `res_ready` is held high.
- Result stream: N*N cycles minimum.
- Total job time with `res_ready`=1: 2 + K + 2N-2 + N*N cycles.
  - Default parameters: 2+10+16 = 28 cycles from `start` to `done`.
- Edge outputs are registered, except lane 0, which is combinational from `*_rd_data`.
- `res_data` is combinational from `pe_out_flat`, muxed by registered indices.

## Structure

Shared package `systolic_pkg`:
- State enum.
- Localparams for F and for counter widths (clog2 of K, N and F).
- Result-width function 2DW+1.

Sub-module `systolic_skew`:
- Parameterised by `DW` and `N`.
- Lane i is a depth-i shift register with a zero-fill enable.
- Instantiated twice, once for the x edge and once for the y edge.

## Test plan

- **Identity:** A = I, B[k][j] = k*4+j+1, default parameters. Results must equal B row-major (1..16) with `done` at cycle 28.
- **Extremes:** A = B = all 127. All results must be 64516.
  - Rerun with A = all -128, B = all 127. All results must be -65024.
- **Back-pressure:** `res_ready` low for 3 cycles at result 5. `res_data`, `res_row` and `res_col` must hold, with no result skipped or duplicated.
- **Busy start:** pulse `start` during FEED. There must be no restart, and exactly one `done`.
- **Back-to-back clear:** two jobs back-to-back. `arr_clr` must pulse once per job, and the second job's results must exclude the first job's sums.
- **Reset mid-job:** `rst` at FEED f=3. Next cycle must show IDLE with all outputs 0. A following job must produce the correct results.
